fetch_unit: RTL and testbench

//  Program-counter and fetch sequencer placed directly upstream of InstructionMemory.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC sequencer and registered fetch stage in front of InstructionMemory.
// Optional feature macro: STEP_MODE_EN (adds Step port; retires only on a Step edge).
// Revision: 1.0
// ============================================================================
module fetch_unit #(
  parameter int IMEM_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      InstructIn,
  input  logic             BranchTaken,
  input  logic [31:0]      RegTarget,
  input  logic             InValid,
`ifdef STEP_MODE_EN
  input  logic             Step,
`endif
  output logic [31:0]      PC,
  output logic [31:0]      InstructOut,
  output logic             InstructVld,
  output logic             InReq,
  output logic             Halted,
  output logic [CNT_W-1:0] RetiredCnt
);

  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [5:0] OP_BEQ  = 6'b001101;
  localparam logic [5:0] OP_BNE  = 6'b001110;
  localparam logic [5:0] OP_BGT  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b010001;
  localparam logic [5:0] OP_JR   = 6'b010010;
  localparam logic [5:0] OP_IN   = 6'b010011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_IN = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    pc_inc;
  logic [AW-1:0]    pc_next;
  logic [31:0]      j_target;
  logic [5:0]       op;
  logic             run_en;
  logic             in_stall;
  logic             in_req_q;
  logic [31:0]      instr_q;
  logic             vld_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_bits;

  assign op       = InstructIn[31:26];
  assign pc_inc   = pc_q + {{(AW-1){1'b0}}, 1'b1};
  assign j_target = {21'd0, InstructIn[10:0]};

  // All targets are reduced to the low AW bits, which is the modulo-depth wrap.
  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_BEQ, OP_BNE, OP_BGT: if (BranchTaken) pc_next = RegTarget[AW-1:0];
      OP_J:                   pc_next = j_target[AW-1:0];
      OP_JR:                  pc_next = RegTarget[AW-1:0];
      default:                pc_next = pc_inc;
    endcase
  end

`ifdef STEP_MODE_EN
  logic step_s1;
  logic step_s2;
  logic step_s3;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      step_s1 <= Step;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  assign run_en = step_s2 & ~step_s3;
`else
  assign run_en = 1'b1;
`endif

  assign in_stall = (state == S_RUN) && run_en && (op == OP_IN) && !InValid;

  // The stall cycle itself raises InReq before the registered copy takes over.
  assign InReq = in_req_q | (in_stall & Reset);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= S_RUN;
      pc_q     <= '0;
      instr_q  <= '0;
      vld_q    <= 1'b0;
      in_req_q <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state)
        S_RUN: begin
          if (run_en) begin
            if (in_stall) begin
              in_req_q <= 1'b1;
              state    <= S_WAIT_IN;
            end else begin
              instr_q <= InstructIn;
              vld_q   <= 1'b1;
              if (~&cnt_q) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
              if (op == OP_HALT) begin
                halted_q <= 1'b1;
                state    <= S_HALT;
              end else begin
                pc_q <= pc_next;
              end
            end
          end
        end
        S_WAIT_IN: begin
          if (InValid) begin
            instr_q  <= InstructIn;
            vld_q    <= 1'b1;
            if (~&cnt_q) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            pc_q     <= pc_inc;
            in_req_q <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

  assign PC          = {{(32-AW){1'b0}}, pc_q};
  assign InstructOut = instr_q;
  assign InstructVld = vld_q;
  assign Halted      = halted_q;
  assign RetiredCnt  = cnt_q;

  assign unused_bits = &{1'b0, InstructIn[25:11], RegTarget[31:AW], j_target[31:AW]};

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : randomized scoreboard bench for fetch_unit with a program-level model.
// Revision: 1.0
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH  = 32;
  localparam int CNT_W  = 4;
  localparam int CNTMAX = (1 << CNT_W) - 1;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_LI   = 6'b000110;
  localparam logic [5:0] OP_BEQ  = 6'b001101;
  localparam logic [5:0] OP_BNE  = 6'b001110;
  localparam logic [5:0] OP_BGT  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b010001;
  localparam logic [5:0] OP_JR   = 6'b010010;
  localparam logic [5:0] OP_IN   = 6'b010011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic [31:0]      InstructIn;
  logic             BranchTaken = 1'b0;
  logic [31:0]      RegTarget = '0;
  logic             InValid = 1'b1;
  logic             Step = 1'b0;
  logic [31:0]      PC;
  logic [31:0]      InstructOut;
  logic             InstructVld;
  logic             InReq;
  logic             Halted;
  logic [CNT_W-1:0] RetiredCnt;

  logic [31:0] imem [DEPTH];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;

  // Architectural model state
  int mpc;
  int mcnt;
  bit mwait;
  bit mhalt;
  bit ss[3];

  fetch_unit #(.IMEM_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InstructIn  (InstructIn),
    .BranchTaken (BranchTaken),
    .RegTarget   (RegTarget),
    .InValid     (InValid),
`ifdef STEP_MODE_EN
    .Step        (Step),
`endif
    .PC          (PC),
    .InstructOut (InstructOut),
    .InstructVld (InstructVld),
    .InReq       (InReq),
    .Halted      (Halted),
    .RetiredCnt  (RetiredCnt)
  );

  always #5 Clock = ~Clock;

  assign InstructIn = imem[PC[4:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented instruction must match the oldest predicted retire.
  always @(negedge Clock) begin
    exp_t e;
    if (Reset && InstructVld) begin
      if (sbq.size() == 0) begin
        check("unexpected_vld", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("instruct_out", InstructOut, e.instr);
        check("pc_after_retire", PC, e.pc);
        check("retired_cnt", {{(32-CNT_W){1'b0}}, RetiredCnt}, e.cnt);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] lo);
    return {op, lo};
  endfunction

  function automatic logic [31:0] rand_word();
    int r;
    logic [25:0] lo;
    r  = $urandom_range(0, 99);
    lo = 26'($urandom);
    if (r < 25)      return mk(6'($urandom), lo);
    else if (r < 40) return mk(OP_NOP, lo);
    else if (r < 55) return mk(($urandom_range(0, 2) == 0) ? OP_BEQ :
                               ($urandom_range(0, 1) == 0) ? OP_BNE : OP_BGT, lo);
    else if (r < 65) return mk(OP_J, lo);
    else if (r < 75) return mk(OP_JR, lo);
    else if (r < 97) return mk(OP_IN, lo);
    else             return mk(OP_HALT, lo);
  endfunction

  task automatic fill_nops();
    for (int i = 0; i < DEPTH; i++) imem[i] = mk(OP_NOP, 26'(i));
  endtask

  task automatic retire(input logic [31:0] w, input int nxt);
    exp_t e;
    mcnt    = (mcnt >= CNTMAX) ? CNTMAX : mcnt + 1;
    e.instr = w;
    e.pc    = nxt;
    e.cnt   = mcnt;
    sbq.push_back(e);
    mpc = nxt;
  endtask

  // Called shortly after a falling edge; predicts the coming rising edge.
  task automatic cycle(input bit rnd);
    logic [31:0] w;
    logic [5:0]  op;
    bit          en;
    bit          stall;
    int          nxt;
    check("pc", PC, mpc);
    check("halted", {31'd0, Halted}, {31'd0, mhalt});
    if (rnd) begin
      BranchTaken = 1'($urandom_range(0, 1));
      RegTarget   = $urandom_range(0, 63);
      InValid     = ($urandom_range(0, 2) == 0);
`ifdef STEP_MODE_EN
      Step        = ($urandom_range(0, 2) == 0);
`endif
    end
    #1;
    w  = imem[mpc];
    op = w[31:26];
    en = 1'b1;
`ifdef STEP_MODE_EN
    en    = ss[1] && !ss[2];
    ss[2] = ss[1];
    ss[1] = ss[0];
    ss[0] = Step;
`endif
    stall = !mhalt && !mwait && en && (op == OP_IN) && !InValid;
    check("in_req", {31'd0, InReq}, {31'd0, (mwait || stall)});
    if (!mhalt) begin
      if (mwait) begin
        if (InValid) begin
          mwait = 1'b0;
          retire(w, (mpc + 1) % DEPTH);
        end
      end else if (en) begin
        if (stall) begin
          mwait = 1'b1;
        end else begin
          nxt = (mpc + 1) % DEPTH;
          if (op == OP_BEQ || op == OP_BNE || op == OP_BGT) begin
            if (BranchTaken) nxt = RegTarget % DEPTH;
          end else if (op == OP_J) begin
            nxt = int'(w[10:0]) % DEPTH;
          end else if (op == OP_JR) begin
            nxt = RegTarget % DEPTH;
          end else if (op == OP_HALT) begin
            nxt   = mpc;
            mhalt = 1'b1;
          end
          retire(w, nxt);
        end
      end
    end
    @(negedge Clock);
    #1;
  endtask

  task automatic drive(input bit bt, input int rt, input bit iv);
    BranchTaken = bt;
    RegTarget   = rt;
    InValid     = iv;
    cycle(1'b0);
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic do_reset();
    Reset = 1'b0;
    #1;
    check("rst_pc", PC, 32'd0);
    check("rst_instr", InstructOut, 32'd0);
    check("rst_vld", {31'd0, InstructVld}, 32'd0);
    check("rst_inreq", {31'd0, InReq}, 32'd0);
    check("rst_halted", {31'd0, Halted}, 32'd0);
    check("rst_cnt", {{(32-CNT_W){1'b0}}, RetiredCnt}, 32'd0);
    check("pending_retires", sbq.size(), 32'd0);
    sbq.delete();
    mpc   = 0;
    mcnt  = 0;
    mwait = 1'b0;
    mhalt = 1'b0;
    ss    = '{default: 1'b0};
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    int cnt_snap;
    fill_nops();
    @(negedge Clock);
    #1;
    do_reset();

`ifdef STEP_MODE_EN
    Step = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0);
    check("step_idle_pc", PC, 32'd0);
    for (int p = 0; p < 2; p++) begin
      Step = 1'b1;
      cycle(1'b0);
      cycle(1'b0);
      Step = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b0);
    end
    check("step_two_pulses_pc", PC, 32'd2);
    check("step_two_pulses_cnt", {{(32-CNT_W){1'b0}}, RetiredCnt}, 32'd2);
`else
    // Reset mid-run at PC=5, then restart with an li word at address 0.
    imem[0] = mk(OP_LI, 26'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1);
    check("run_pc5", PC, 32'd5);
    do_reset();
    drive(1'b0, 0, 1'b1);
    check("li_out", InstructOut, mk(OP_LI, 26'd1));
    check("li_vld", {31'd0, InstructVld}, 32'd1);
    check("li_pc", PC, 32'd1);
    check("li_cnt", {{(32-CNT_W){1'b0}}, RetiredCnt}, 32'd1);
    drive(1'b0, 0, 1'b1);
    check("pc2", PC, 32'd2);

    // Control-flow walk: j, taken/untaken bgt, j, truncated jr, wrap at 31.
    fill_nops();
    imem[0]  = mk(OP_J,   26'd12);
    imem[12] = mk(OP_BGT, 26'd0);
    imem[10] = mk(OP_BGT, 26'd0);
    imem[11] = mk(OP_J,   26'd14);
    imem[14] = mk(OP_JR,  26'd0);
    imem[1]  = mk(OP_J,   26'd31);
    do_reset();
    drive(1'b0, 0, 1'b1);   check("j12", PC, 32'd12);
    drive(1'b1, 10, 1'b1);  check("bgt_taken", PC, 32'd10);
    drive(1'b0, 10, 1'b1);  check("bgt_not_taken", PC, 32'd11);
    drive(1'b0, 0, 1'b1);   check("j14", PC, 32'd14);
    drive(1'b0, 33, 1'b1);  check("jr_trunc", PC, 32'd1);
    drive(1'b0, 0, 1'b1);   check("j31", PC, 32'd31);
    drive(1'b0, 0, 1'b1);   check("wrap", PC, 32'd0);

    // Input stall at PC=2.
    fill_nops();
    imem[2] = mk(OP_IN, 26'd7);
    do_reset();
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0);
    check("stall_pc", PC, 32'd2);
    check("stall_inreq", {31'd0, InReq}, 32'd1);
    drive(1'b0, 0, 1'b1);
    check("in_retired_pc", PC, 32'd3);
    check("in_retired_inreq", {31'd0, InReq}, 32'd0);

    // Halt at PC=13 freezes everything until reset.
    fill_nops();
    imem[13] = mk(OP_HALT, 26'd0);
    do_reset();
    for (int i = 0; i < 14; i++) drive(1'b0, 0, 1'b1);
    cnt_snap = RetiredCnt;
    for (int i = 0; i < 10; i++) drive(1'b1, 3, 1'b1);
    check("halt_pc", PC, 32'd13);
    check("halt_flag", {31'd0, Halted}, 32'd1);
    check("halt_cnt_frozen", {{(32-CNT_W){1'b0}}, RetiredCnt}, 32'd14);
    check("halt_cnt_stable", {{(32-CNT_W){1'b0}}, RetiredCnt}, cnt_snap);
    do_reset();
    drive(1'b0, 0, 1'b1);
    check("post_halt_pc", PC, 32'd1);
`endif

    // Random programs and random datapath inputs.
    for (int ep = 0; ep < 20; ep++) begin
      for (int i = 0; i < DEPTH; i++) imem[i] = rand_word();
      do_reset();
      for (int c = 0; c < 150; c++) cycle(1'b1);
    end

    @(negedge Clock);
    check("final_pending", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
